pp_pipeline_accel_fifo_wr_arb: RTL and testbench
================================================

PP_PIPELINE_ACCEL_FIFO_WR_ARB -- requirements
Module: pp_pipeline_accel_fifo_wr_arb

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 64, width of each data word.
REQ-002 SHALL have parameter NUM_REQ, default 4, number of write requesters (2..8).
REQ-003 SHALL have parameter BURST_MAX, default 16, maximum beats per grant (1..256).
REQ-004 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-005 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port req_write  input  NUM_REQ  per-requester write strobe.
REQ-007 SHALL have port req_din  input  NUM_REQ*DATA_WIDTH  per-requester data; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-008 SHALL have port req_full_n  output  NUM_REQ  per-requester space-available indication.
REQ-009 SHALL have port fifo_write  output  1  write strobe to the shared downstream FIFO (if_write side; if_write_ce tied high externally).
REQ-010 SHALL have port fifo_din  output  DATA_WIDTH  data to the shared FIFO.
REQ-011 SHALL have port fifo_full_n  input  1  shared FIFO not-full.
REQ-012 SHALL have port grant_id  output  clog2(NUM_REQ)  index of the current grantee; valid only while busy=1.
REQ-013 SHALL have port busy  output  1  high while a grant is held.

Function
REQ-014 SHALL implement a two-state FSM: IDLE and GRANT.
REQ-015 In IDLE with any req_write bit high, SHALL select the first requesting index in round-robin order starting at last_grant+1 (mod NUM_REQ) and enter GRANT next cycle; arbitration latency is exactly 1 cycle.
REQ-016 In IDLE, SHALL drive fifo_write=0, all req_full_n=0, busy=0.
REQ-017 In GRANT, SHALL drive fifo_write=req_write[grant_id], fifo_din=req_din[grant_id], req_full_n[grant_id]=fifo_full_n, all other req_full_n bits 0; these are combinational, with no added latency.
REQ-018 SHALL count a beat only when fifo_write=1 and fifo_full_n=1 in the same cycle.
REQ-019 SHALL hold an 8-bit beat counter, cleared on GRANT entry and incremented per beat.
REQ-020 SHALL return to IDLE after the beat that makes the counter equal BURST_MAX.
REQ-021 SHALL return to IDLE in any GRANT cycle where req_write[grant_id]=0; no beat occurs in that cycle.
REQ-022 SHALL keep the grant while fifo_full_n=0 and req_write[grant_id]=1, with no beats counted and no timeout.
REQ-023 SHALL update last_grant to the selected index on GRANT entry.
REQ-024 SHALL never assert more than one req_full_n bit in any cycle.
REQ-025 SHALL ignore requester writes issued while that requester's req_full_n=0; data is not captured.
REQ-026 After a release, SHALL re-arbitrate in IDLE, so each grant is separated by exactly one idle cycle.
REQ-027 When only one requester is active, SHALL re-grant that same requester after the idle cycle.

Reset
REQ-028 On reset_n=0, SHALL immediately force state=IDLE, last_grant=NUM_REQ-1 (so requester 0 has first priority), beat counter=0, grant_id=0, busy=0, fifo_write=0, and all req_full_n=0.
REQ-029 Reset asserted mid-burst SHALL abort the burst; no fifo_write occurs in or after the reset cycle until a new grant.
REQ-030 SHALL take its first arbitration decision on the first clk edge after reset_n deasserts.

Structure
REQ-031 SHALL place FSM state encoding (IDLE=0, GRANT=1) and the beat counter width constant in the shared package pp_pipeline_accel_arb_pkg.
REQ-032 SHALL put the round-robin selector in one sub-module, pp_pipeline_accel_rr_pick (inputs: request vector, last index; outputs: index, valid); the rest stays in the top module.
REQ-033 SHALL not instantiate the downstream FIFO; the FIFO connects at the parent level.

Verification
REQ-034 Reset, then req_write=4'b0001 for 5 beats with fifo_full_n=1 -> grant_id=0 one cycle later, 5 beats delivered, release when req_write drops.
REQ-035 req_write=4'b1111 held, BURST_MAX=16, fifo_full_n=1 -> grants 0,1,2,3,0 in order, each exactly 16 beats, one idle cycle between grants.
REQ-036 Grant to req 2, fifo_full_n=0 for 10 cycles mid-burst -> req_full_n[2]=0 during the stall, beat count frozen, grant held, burst resumes and completes.
REQ-037 Grant to req 1, then req 3 raises req_write -> req_full_n[3]=0 until req 1 releases; next grant goes to 3, and req 0 is skipped even if it is requesting only after req 3 raised.
REQ-038 reset_n pulsed low after beat 7 of a 16-beat burst -> fifo_write=0 immediately, busy=0; the next grant goes to req 0.
REQ-039 Scoreboard over all scenarios -> fifo_din stream equals per-requester ordered data with no loss or duplication, and at most one req_full_n bit is high in every cycle.

Source files
------------

// File: rtl/pp_pipeline_accel_arb_pkg.sv
// pp_pipeline_accel_arb_pkg: FSM encoding and beat counter width shared by the write arbiter.
package pp_pipeline_accel_arb_pkg;
    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_GRANT = 1'b1;
    localparam int         CNT_W    = 8;
endpackage

// File: rtl/pp_pipeline_accel_fifo_wr_arb_if.sv
// pp_pipeline_accel_fifo_wr_arb_if: requester-side and shared-FIFO-side signals of the write arbiter.
interface pp_pipeline_accel_fifo_wr_arb_if #(
    parameter int DATA_WIDTH = 64,
    parameter int NUM_REQ    = 4
);
    localparam int IDX_W = $clog2(NUM_REQ);
    logic [NUM_REQ-1:0]            req_write;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_din;
    logic [NUM_REQ-1:0]            req_full_n;
    logic                          fifo_write;
    logic [DATA_WIDTH-1:0]         fifo_din;
    logic                          fifo_full_n;
    logic [IDX_W-1:0]              grant_id;
    logic                          busy;
    modport master (
        output req_write, req_din, fifo_full_n,
        input  req_full_n, fifo_write, fifo_din, grant_id, busy
    );
    modport slave (
        input  req_write, req_din, fifo_full_n,
        output req_full_n, fifo_write, fifo_din, grant_id, busy
    );
endinterface

// File: rtl/pp_pipeline_accel_rr_pick.sv
// pp_pipeline_accel_rr_pick: first requesting index in round-robin order starting after i_last.
module pp_pipeline_accel_rr_pick #(
    parameter  int NUM_REQ = 4,
    localparam int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [IDX_W-1:0]   i_last,
    output logic [IDX_W-1:0]   o_idx,
    output logic               o_valid
);
    logic [IDX_W-1:0] w_j;
    // Scan from farthest to nearest so the nearest requester after i_last wins.
    always_comb begin
        o_idx   = '0;
        o_valid = |i_req;
        w_j     = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            w_j = IDX_W'((int'(i_last) + k) % NUM_REQ);
            if (i_req[w_j]) o_idx = w_j;
        end
    end
endmodule

// File: rtl/pp_pipeline_accel_fifo_wr_arb.sv
// pp_pipeline_accel_fifo_wr_arb: round-robin burst arbiter funnelling NUM_REQ writers into one shared FIFO.
module pp_pipeline_accel_fifo_wr_arb
    import pp_pipeline_accel_arb_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int NUM_REQ    = 4,
    parameter int BURST_MAX  = 16
) (
    input  logic                          clk,
    input  logic                          reset_n,
    pp_pipeline_accel_fifo_wr_arb_if.slave bus
);
    localparam int             IDX_W      = $clog2(NUM_REQ);
    localparam logic [CNT_W:0] BURST_LAST = (CNT_W + 1)'(BURST_MAX);

    logic [0:0]       r_state;
    logic [IDX_W-1:0] r_last;
    logic [IDX_W-1:0] r_gid;
    logic [CNT_W-1:0] r_cnt;
    logic [IDX_W-1:0] w_pick;
    logic             w_pick_vld;
    logic             w_busy;
    logic             w_wr;
    logic             w_beat;
    logic [CNT_W:0]   w_cnt_nxt;

    pp_pipeline_accel_rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
        .i_req   (bus.req_write),
        .i_last  (r_last),
        .o_idx   (w_pick),
        .o_valid (w_pick_vld)
    );

    assign w_busy    = r_state == ST_GRANT;
    assign w_wr      = w_busy && bus.req_write[r_gid];
    assign w_beat    = w_wr && bus.fifo_full_n;
    assign w_cnt_nxt = {1'b0, r_cnt} + (CNT_W + 1)'(1);

    // Counter is one bit wider in the compare so BURST_MAX=256 still terminates.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
            r_last  <= IDX_W'(NUM_REQ - 1);
            r_gid   <= '0;
            r_cnt   <= '0;
        end else if (!w_busy) begin
            if (w_pick_vld) begin
                r_state <= ST_GRANT;
                r_gid   <= w_pick;
                r_last  <= w_pick;
                r_cnt   <= '0;
            end
        end else if (!w_wr || (w_beat && w_cnt_nxt == BURST_LAST)) begin
            r_state <= ST_IDLE;
        end else if (w_beat) begin
            r_cnt <= w_cnt_nxt[CNT_W-1:0];
        end
    end

    assign bus.busy       = w_busy;
    assign bus.grant_id   = r_gid;
    assign bus.fifo_write = w_wr;
    assign bus.fifo_din   = bus.req_din[int'(r_gid) * DATA_WIDTH +: DATA_WIDTH];
    assign bus.req_full_n = (w_busy && bus.fifo_full_n) ? NUM_REQ'(1) << r_gid : '0;
endmodule

// File: tb/tb_pp_pipeline_accel_fifo_wr_arb.sv
// tb_pp_pipeline_accel_fifo_wr_arb: directed scenarios plus a data/grant scoreboard for the write arbiter.
module tb_pp_pipeline_accel_fifo_wr_arb;
    typedef struct {
        logic [3:0] rw;
        logic       fnf;
        logic       fw;
        logic [3:0] rfn;
    } vec_t;
    typedef struct {
        int id;
        int beats;
        int gap;
    } grant_t;

    logic        clk;
    logic        reset_n;
    int          n_chk;
    int          n_fail;
    int          n[4];
    logic [63:0] exp_q[$];
    grant_t      glog[$];
    vec_t        tbl[7];
    bit          in_g;
    int          idle;
    int          cur_id;
    int          cur_beats;
    logic [3:0]  hs;

    pp_pipeline_accel_fifo_wr_arb_if #(.DATA_WIDTH(64), .NUM_REQ(4)) bus ();

    pp_pipeline_accel_fifo_wr_arb #(.DATA_WIDTH(64), .NUM_REQ(4), .BURST_MAX(16)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] word(input int i, input int k);
        return {8'(i), 56'(k)};
    endfunction

    always_comb begin
        bus.req_din = '0;
        for (int i = 0; i < 4; i++) bus.req_din[i*64 +: 64] = word(i, n[i]);
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic exp_grant(input int id, input int beats, input int gap);
        grant_t g;
        if (glog.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL grant_log: no grant recorded, expected id %0d beats %0d", id, beats);
        end else begin
            g = glog.pop_front();
            chk("grant_seq_id", 64'(g.id), 64'(id));
            chk("grant_beats", 64'(g.beats), 64'(beats));
            if (gap >= 0) chk("grant_idle_gap", 64'(g.gap), 64'(gap));
        end
    endtask

    // Monitor: pushes each accepted requester word, pops it on the matching FIFO beat, logs grants.
    initial begin
        for (int i = 0; i < 4; i++) n[i] = 0;
        in_g = 0;
        idle = 0;
        cur_id = 0;
        cur_beats = 0;
        forever begin
            @(negedge clk);
            #2;
            hs = '0;
            chk("full_n_onehot", 64'($countones(bus.req_full_n) <= 1), 64'(1));
            for (int i = 0; i < 4; i++)
                if (bus.req_write[i] && bus.req_full_n[i]) begin
                    exp_q.push_back(word(i, n[i]));
                    hs[i] = 1'b1;
                end
            if (bus.busy) begin
                if (!in_g) begin
                    in_g = 1;
                    cur_id = int'(bus.grant_id);
                    cur_beats = 0;
                end
                if (bus.fifo_write && bus.fifo_full_n) begin
                    cur_beats++;
                    if (exp_q.size() == 0) begin
                        n_chk++;
                        n_fail++;
                        $display("FAIL fifo_beat: unexpected word %0h with no accepted write", bus.fifo_din);
                    end else chk("fifo_din_stream", bus.fifo_din, exp_q.pop_front());
                    chk("beat_source", 64'(bus.fifo_din[63:56]), 64'(cur_id));
                end
            end else begin
                if (in_g) begin
                    glog.push_back('{cur_id, cur_beats, idle});
                    in_g = 0;
                    idle = 0;
                end
                idle++;
            end
            if (!reset_n) idle = 0;
            @(posedge clk);
            #1;
            for (int i = 0; i < 4; i++) if (hs[i]) n[i]++;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, failures so far %0d", n_fail);
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        int n3;
        tbl[0] = '{4'b0100, 1'b0, 1'b1, 4'b0000};
        tbl[1] = '{4'b0100, 1'b1, 1'b1, 4'b0100};
        tbl[2] = '{4'b1111, 1'b0, 1'b1, 4'b0000};
        tbl[3] = '{4'b1111, 1'b1, 1'b1, 4'b0100};
        tbl[4] = '{4'b0110, 1'b1, 1'b1, 4'b0100};
        tbl[5] = '{4'b1101, 1'b0, 1'b1, 4'b0000};
        tbl[6] = '{4'b0100, 1'b1, 1'b1, 4'b0100};
        n_chk = 0;
        n_fail = 0;
        reset_n = 1'b0;
        bus.req_write = 4'b1111;
        bus.fifo_full_n = 1'b1;
        @(negedge clk);
        #1;
        chk("rst_busy", 64'(bus.busy), 64'(0));
        chk("rst_fifo_write", 64'(bus.fifo_write), 64'(0));
        chk("rst_full_n", 64'(bus.req_full_n), 64'(0));
        chk("rst_grant_id", 64'(bus.grant_id), 64'(0));

        // Single requester, 5 beats, release on req_write drop.
        @(negedge clk);
        reset_n = 1'b1;
        bus.req_write = 4'b0001;
        #1;
        chk("a_no_early_grant", 64'(bus.busy), 64'(0));
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            #1;
            chk("a_busy", 64'(bus.busy), 64'(1));
            chk("a_gid", 64'(bus.grant_id), 64'(0));
            chk("a_fifo_write", 64'(bus.fifo_write), 64'(1));
            chk("a_full_n", 64'(bus.req_full_n), 64'(4'b0001));
        end
        @(negedge clk);
        bus.req_write = 4'b0000;
        #1;
        chk("a_drop_fifo_write", 64'(bus.fifo_write), 64'(0));
        @(negedge clk);
        #1;
        chk("a_released", 64'(bus.busy), 64'(0));
        repeat (2) @(negedge clk);
        #3;
        exp_grant(0, 5, 1);

        // All four requesting: 0,1,2,3,0 with 16 beats each and one idle cycle between.
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        bus.req_write = 4'b1111;
        for (int c = 1; c <= 85; c++) begin
            @(negedge clk);
            #1;
            chk("b_busy", 64'(bus.busy), 64'((c % 17) != 0));
            if (c % 17 != 0) chk("b_gid", 64'(bus.grant_id), 64'(((c - 1) / 17) % 4));
        end
        bus.req_write = 4'b0000;
        repeat (2) @(negedge clk);
        #3;
        exp_grant(0, 16, 1);
        exp_grant(1, 16, 1);
        exp_grant(2, 16, 1);
        exp_grant(3, 16, 1);
        exp_grant(0, 16, 1);

        // Grant to 2: combinational vectors, 10-cycle stall, resume, then re-grant of lone requester.
        @(negedge clk);
        bus.req_write = 4'b0100;
        for (int v = 0; v < 7; v++) begin
            @(negedge clk);
            bus.req_write = tbl[v].rw;
            bus.fifo_full_n = tbl[v].fnf;
            #1;
            chk("c_tbl_busy", 64'(bus.busy), 64'(1));
            chk("c_tbl_gid", 64'(bus.grant_id), 64'(2));
            chk("c_tbl_fifo_write", 64'(bus.fifo_write), 64'(tbl[v].fw));
            chk("c_tbl_full_n", 64'(bus.req_full_n), 64'(tbl[v].rfn));
            chk("c_tbl_fifo_din", bus.fifo_din, word(2, n[2]));
        end
        for (int s = 0; s < 10; s++) begin
            @(negedge clk);
            bus.req_write = 4'b0100;
            bus.fifo_full_n = 1'b0;
            #1;
            chk("c_stall_full_n", 64'(bus.req_full_n), 64'(0));
            chk("c_stall_busy", 64'(bus.busy), 64'(1));
        end
        @(negedge clk);
        bus.fifo_full_n = 1'b1;
        #1;
        w = 0;
        while (bus.busy && w < 40) begin
            @(negedge clk);
            #1;
            w++;
        end
        chk("c_resume_cycles", 64'(w), 64'(12));
        @(negedge clk);
        #1;
        chk("c_regrant_busy", 64'(bus.busy), 64'(1));
        chk("c_regrant_gid", 64'(bus.grant_id), 64'(2));
        @(negedge clk);
        @(negedge clk);
        bus.req_write = 4'b0000;
        #1;
        chk("c_drop_fifo_write", 64'(bus.fifo_write), 64'(0));
        @(negedge clk);
        #1;
        chk("c_released", 64'(bus.busy), 64'(0));

        // Grant to 1 while 3 then 0 request; 3 must be next.
        n3 = n[3];
        @(negedge clk);
        bus.req_write = 4'b0010;
        @(negedge clk);
        bus.req_write = 4'b1010;
        #1;
        chk("d_gid1", 64'(bus.grant_id), 64'(1));
        chk("d_full_n_a", 64'(bus.req_full_n), 64'(4'b0010));
        chk("d_fifo_din", bus.fifo_din, word(1, n[1]));
        @(negedge clk);
        bus.req_write = 4'b1011;
        #1;
        chk("d_full_n_b", 64'(bus.req_full_n), 64'(4'b0010));
        @(negedge clk);
        bus.req_write = 4'b1001;
        #1;
        chk("d_drop_fifo_write", 64'(bus.fifo_write), 64'(0));
        @(negedge clk);
        #1;
        chk("d_idle", 64'(bus.busy), 64'(0));
        @(negedge clk);
        #1;
        chk("d_gid3", 64'(bus.grant_id), 64'(3));
        chk("d_full_n_c", 64'(bus.req_full_n), 64'(4'b1000));
        @(negedge clk);
        @(negedge clk);
        bus.req_write = 4'b0000;
        #1;
        chk("d_req3_accepted", 64'(n[3] - n3), 64'(2));

        // Reset after beat 7 of a burst to 0; afterwards 0 must still win over 1.
        @(negedge clk);
        bus.req_write = 4'b0001;
        repeat (7) @(negedge clk);
        @(negedge clk);
        reset_n = 1'b0;
        bus.req_write = 4'b0011;
        #1;
        chk("e_rst_fifo_write", 64'(bus.fifo_write), 64'(0));
        chk("e_rst_busy", 64'(bus.busy), 64'(0));
        chk("e_rst_full_n", 64'(bus.req_full_n), 64'(0));
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        chk("e_post_rst_idle", 64'(bus.busy), 64'(0));
        @(negedge clk);
        #1;
        chk("e_busy", 64'(bus.busy), 64'(1));
        chk("e_gid0", 64'(bus.grant_id), 64'(0));
        @(negedge clk);
        @(negedge clk);
        bus.req_write = 4'b0000;
        repeat (3) @(negedge clk);
        #3;
        exp_grant(2, 16, -1);
        exp_grant(2, 2, 1);
        exp_grant(1, 2, -1);
        exp_grant(3, 2, 1);
        exp_grant(0, 7, -1);
        exp_grant(0, 2, 1);
        chk("grant_log_empty", 64'(glog.size()), 64'(0));
        chk("scoreboard_empty", 64'(exp_q.size()), 64'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
